// File: rtl/sort_result_streamer.sv
// rtl/sort_result_streamer.sv - captures a sorter's packed result and streams it out per element
// while flagging any descending step as an order error.
module sort_result_streamer #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            done,
    input  logic [N*W-1:0]  data_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [IW-1:0]   out_index,
    output logic            out_last,
    output logic            busy,
    output logic            order_err,
    output logic            overrun
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state_q, state_d;
    logic            done_q;
    logic [W-1:0]    frame_q [N];
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    prev_q;
    logic            order_err_q;
    logic            overrun_q;
    logic            cap, xfer, at_last, last_xfer, load;

    assign cap       = done & ~done_q;
    assign out_valid = (state_q == STREAM);
    assign busy      = out_valid;
    assign out_data  = frame_q[idx_q];
    assign out_index = idx_q;
    assign at_last   = (idx_q == IW'(N - 1));
    assign out_last  = out_valid & at_last;
    assign xfer      = out_valid & out_ready;
    assign last_xfer = xfer & at_last;
    assign order_err = order_err_q;
    assign overrun   = overrun_q;
    // A capture edge is honoured from IDLE or when it coincides with the final beat (no bubble).
    assign load      = cap & ((state_q == IDLE) | last_xfer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cap) state_d = STREAM;
            STREAM:  if (last_xfer && !cap) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // done_q starts high so a done already asserted at reset release is not an edge.
            done_q      <= 1'b1;
            idx_q       <= '0;
            prev_q      <= '0;
            order_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < N; i++) frame_q[i] <= '0;
        end else begin
            done_q    <= done;
            overrun_q <= cap & (state_q == STREAM) & ~last_xfer;
            if (load) begin
                for (int i = 0; i < N; i++) frame_q[i] <= data_in[i*W +: W];
                idx_q       <= '0;
                order_err_q <= 1'b0;
            end else if (xfer) begin
                if (!at_last) begin
                    idx_q  <= idx_q + IW'(1);
                    prev_q <= out_data;
                end
                if (idx_q != '0 && out_data < prev_q) order_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sort_result_streamer.sv
// tb/tb_sort_result_streamer.sv - directed self-checking bench for sort_result_streamer.
module tb_sort_result_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        done;
    logic [31:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        order_err;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    sort_result_streamer #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .done      (done),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .order_err (order_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic [1:0] i, input logic l);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".data"},  out_data,  d);
        check({tag, ".index"}, out_index, i);
        check({tag, ".last"},  out_last,  l);
    endtask

    task automatic all_zero(input string tag);
        check({tag, ".valid"},   out_valid, 1'b0);
        check({tag, ".data"},    out_data,  8'h00);
        check({tag, ".index"},   out_index, 2'd0);
        check({tag, ".last"},    out_last,  1'b0);
        check({tag, ".busy"},    busy,      1'b0);
        check({tag, ".ordererr"}, order_err, 1'b0);
        check({tag, ".overrun"}, overrun,   1'b0);
    endtask

    // Called at a negedge; returns at the negedge where element 0 is presented.
    task automatic start_frame(input logic [31:0] d);
        done = 1'b0;
        @(negedge clk);
        data_in = d;
        done    = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        done      = 1'b1;
        data_in   = 32'h0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("held_done.valid", out_valid, 1'b0);

        // Sorted frame, continuous ready
        start_frame(32'h7856_3412);
        beat("s0", 8'h12, 2'd0, 1'b0); @(negedge clk);
        beat("s1", 8'h34, 2'd1, 1'b0); @(negedge clk);
        beat("s2", 8'h56, 2'd2, 1'b0); @(negedge clk);
        beat("s3", 8'h78, 2'd3, 1'b1);
        check("s3.ordererr", order_err, 1'b0);
        @(negedge clk);
        check("s.busy_after", busy, 1'b0);
        check("s.ordererr_after", order_err, 1'b0);

        // Backpressure for 3 cycles at index 1
        start_frame(32'h7856_3412);
        beat("b0", 8'h12, 2'd0, 1'b0); @(negedge clk);
        beat("b1", 8'h34, 2'd1, 1'b0);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            beat("b_stall", 8'h34, 2'd1, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        beat("b2", 8'h56, 2'd2, 1'b0); @(negedge clk);
        beat("b3", 8'h78, 2'd3, 1'b1); @(negedge clk);
        check("b.busy_after", busy, 1'b0);

        // Unsorted frame: 56, 78, 34, 12
        start_frame(32'h1234_7856);
        beat("u0", 8'h56, 2'd0, 1'b0); @(negedge clk);
        beat("u1", 8'h78, 2'd1, 1'b0); @(negedge clk);
        beat("u2", 8'h34, 2'd2, 1'b0);
        check("u2.ordererr", order_err, 1'b0);
        @(negedge clk);
        beat("u3", 8'h12, 2'd3, 1'b1);
        check("u3.ordererr", order_err, 1'b1);
        @(negedge clk);
        check("u.busy_after", busy, 1'b0);
        check("u.ordererr_sticky", order_err, 1'b1);

        // Equal pairs clear the error and raise none
        start_frame(32'h0404_0101);
        beat("e0", 8'h01, 2'd0, 1'b0);
        check("e0.ordererr_cleared", order_err, 1'b0);
        @(negedge clk);
        beat("e1", 8'h01, 2'd1, 1'b0); @(negedge clk);
        beat("e2", 8'h04, 2'd2, 1'b0); @(negedge clk);
        beat("e3", 8'h04, 2'd3, 1'b1); @(negedge clk);
        check("e.busy_after", busy, 1'b0);
        check("e.ordererr_after", order_err, 1'b0);

        // Dropped done edge mid-frame
        start_frame(32'h7856_3412);
        beat("o0", 8'h12, 2'd0, 1'b0); @(negedge clk);
        beat("o1", 8'h34, 2'd1, 1'b0);
        done      = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("o.overrun_pre", overrun, 1'b0);
        done    = 1'b1;
        data_in = 32'hFFFF_FFFF;
        @(negedge clk);
        check("o.overrun_pulse", overrun, 1'b1);
        beat("o1_hold", 8'h34, 2'd1, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        check("o.overrun_end", overrun, 1'b0);
        beat("o2", 8'h56, 2'd2, 1'b0); @(negedge clk);
        beat("o3", 8'h78, 2'd3, 1'b1); @(negedge clk);
        check("o.busy_after", busy, 1'b0);

        // Back-to-back recapture on the last transfer
        start_frame(32'h7856_3412);
        beat("r0", 8'h12, 2'd0, 1'b0); @(negedge clk);
        beat("r1", 8'h34, 2'd1, 1'b0); @(negedge clk);
        beat("r2", 8'h56, 2'd2, 1'b0);
        done = 1'b0;
        @(negedge clk);
        beat("r3", 8'h78, 2'd3, 1'b1);
        done    = 1'b1;
        data_in = 32'h0403_0201;
        @(negedge clk);
        beat("n0", 8'h01, 2'd0, 1'b0);
        check("n0.overrun", overrun, 1'b0);
        @(negedge clk);
        beat("n1", 8'h02, 2'd1, 1'b0);
        check("n1.overrun", overrun, 1'b0);
        @(negedge clk);
        beat("n2", 8'h03, 2'd2, 1'b0); @(negedge clk);
        beat("n3", 8'h04, 2'd3, 1'b1); @(negedge clk);
        check("n.busy_after", busy, 1'b0);

        // Asynchronous reset mid-frame
        start_frame(32'h7856_3412);
        @(negedge clk);
        @(negedge clk);
        beat("x2", 8'h56, 2'd2, 1'b0);
        #2 rst_n = 1'b0;
        #1 all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_reset.valid", out_valid, 1'b0);
        end
        start_frame(32'h0403_0201);
        beat("p0", 8'h01, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sort_result_streamer.md
# sort_result_streamer

Consumer-side companion to the sorting blocks in `sorting/`. It captures the packed N-element result word presented with a sorter's `done`, then streams the elements out one per beat over a valid/ready handshake, lowest-indexed element first. While streaming, it checks that the sequence is non-decreasing (unsigned) and flags any violation. It sits between a sorter and any downstream serial consumer, and doubles as an in-system order checker.

## Interface
- `N`, 4: number of elements in the packed word (N ≥ 2).
- `W`, 8: element width in bits.
- `IW`, `$clog2(N)`: index width (derived; do not override).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `done`  in  1  sorter completion; only its rising edge is significant.
- `data_in`  in  N*W  packed sorted word; element i = `data_in[i*W +: W]`.
- `out_valid`  out  1  `out_data` holds a beat.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  W  current element.
- `out_index`  out  IW  index of the current element (0..N-1).
- `out_last`  out  1  current beat is element N-1.
- `busy`  out  1  a frame is held and not yet fully transferred.
- `order_err`  out  1  sticky per frame; a beat was smaller than its predecessor.
- `overrun`  out  1  one-cycle pulse; a `done` rising edge was dropped.

## Operation
- Single clock; reset is asynchronous and active-low (`rst_n`).
- Reset values:
  - `out_valid`, `out_data`, `out_index`, `out_last`, `busy`, `order_err`, `overrun` = 0.
  - State = IDLE.
  - Internal `done` delay register = 1, so a `done` held high through reset release does not capture.
- Edge detect: `cap = done & ~done_q`. `done_q` samples `done` every cycle.
- States:
  - IDLE → STREAM on `cap`.
    - Latch `data_in` into the frame buffer, index = 0, clear `order_err`.
  - STREAM: a beat transfers when `out_valid & out_ready`.
    - On a transfer with index < N-1: index += 1, and the transferred value is stored as `prev`.
    - On a transfer with index = N-1:
      - if `cap` is high in the same cycle: recapture (index 0, `order_err` cleared, stay in STREAM);
      - otherwise go to IDLE.
    - `cap` in STREAM other than at the final transfer: frame buffer unchanged, `overrun` = 1 for the next cycle only.
- Outputs:
  - `out_valid` = `busy` = (state == STREAM).
  - `out_data` = buffer element[index].
  - `out_last` = `out_valid & (index == N-1)`.
- Order check:
  - On a transfer with index ≥ 1 and `out_data < prev` (unsigned), `order_err` is set from the next cycle.
  - It holds until the next capture or reset. Equal values are not an error.
- Handshake rules:
  - While `out_valid & ~out_ready`, `out_data`, `out_index` and `out_last` hold stable.
  - `out_valid` never drops without a transfer, except on reset.
- Reset mid-frame: the frame is discarded immediately and all outputs return to their reset values asynchronously.

## Timing
- Capture latency: `cap` at edge k → `out_valid` = 1 with element 0 after edge k.
- Throughput: one element per cycle with `out_ready` held at 1. N beats occupy N consecutive cycles.
- With continuous ready, `out_valid` drops the cycle after the `out_last` transfer, unless a back-to-back recapture occurs. In that case `out_valid` stays 1 and element 0 of the new frame follows with no bubble.
- `order_err` lags the offending transfer by one cycle. `overrun` lags the dropped edge by one cycle.
- `out_ready` has no combinational path to `out_valid`/`out_data`. All outputs are registered or decoded from state/index only.

## Test plan
- Reset release with `done` = 1 held → no capture; `out_valid` = 0. Then `done` 0→1 with `data_in` = 32'h7856_3412, `out_ready` = 1:
  - beats 12, 34, 56, 78 on consecutive cycles at indices 0–3;
  - `out_last` only with 78;
  - `order_err` = 0;
  - `busy` low the cycle after.
- Same frame with `out_ready` low for 3 cycles while index = 1 → `out_data` holds 34 and `out_index` holds 1 throughout; the sequence completes unchanged.
- Unsorted `data_in` = 32'h1234_7856 → beats 56, 78, 34, 12:
  - `order_err` rises the cycle after the 34 transfer;
  - it stays 1 through frame end;
  - it clears on the next capture of 32'h0404_0101 (equal pairs, no error).
- Second `done` rising edge while index = 1 with `data_in` changed to 32'hFFFF_FFFF → `overrun` pulses 1 cycle; remaining beats are 56, 78 from the original frame.
- `done` rising edge coincident with the `out_last` transfer, new `data_in` = 32'h0403_0201 → no bubble; next beats 01, 02, 03, 04; `overrun` = 0.
- `rst_n` asserted mid-frame at index 2 → all outputs 0 immediately. After release, no beats until a fresh `done` rising edge.
